// File: rtl/useq_pkg.sv
// Shared definitions for the microcode sequencer: where the sequencing bits sit
// in the control word, the trap cause codes, and the datapath flag positions.
package useq_pkg;

  // Sequencing bits are counted down from the MSB: bit index = CTRL_W - OFS_*.
  localparam int OFS_STEP_INC   = 1;
  localparam int OFS_STEP_RESET = 2;
  localparam int OFS_COND       = 3;
  localparam int OFS_WAIT_MEM   = 4;
  localparam int OFS_SUB_MERGE  = 5;
  localparam int SEQ_BITS       = 5;

  localparam int CAUSE_ILLEGAL = 2;
  localparam int CAUSE_EXT_IRQ = 11;

  // Bit positions of the datapath controls in the low part of the word.
  typedef enum logic [4:0] {
    CF_PC_WE   = 5'd0,
    CF_IR_WE   = 5'd1,
    CF_RF_WE   = 5'd2,
    CF_ALU_SRC = 5'd3,
    CF_MEM_RD  = 5'd4,
    CF_MEM_WR  = 5'd5,
    CF_CSR_WE  = 5'd6,
    CF_PC_SEL  = 5'd7
  } ctrl_flags_e;

endpackage

// File: rtl/useq_irq_ctrl.sv
// External interrupt front end: per-line synchroniser, rising-edge detect,
// pending latch and lowest-index-first priority selection.
module useq_irq_ctrl
  import useq_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               take,
  output logic [NUM_IRQ-1:0] pending,
  output logic               any,
  output logic [3:0]         id
);

  logic [NUM_IRQ-1:0] sync_1;
  logic [NUM_IRQ-1:0] sync_2;
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic               found;

  assign rise = sync_2 & ~sync_prev;
  assign any  = |pending;

  always_comb begin
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && !found) begin
        id    = 4'(i);
        found = 1'b1;
      end
    end
  end

  assign clr = take ? (NUM_IRQ'(1) << id) : '0;

  // A fresh edge arriving while its line is being taken keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1    <= '0;
      sync_2    <= '0;
      sync_prev <= '0;
      pending   <= '0;
    end else begin
      sync_1    <= irq;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      pending   <= (pending & ~clr) | rise;
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Run-time loadable microcode sequencer: main/sub control-word tables, step
// sequencing with branch and memory-wait handshakes, traps, interrupts, instret.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int OP_W      = 5,
  parameter int MAX_STEPS = 8,
  parameter int CTRL_W    = 32,
  parameter int NUM_IRQ   = 4,
  parameter int CAUSE_W   = 5,
  localparam int STEP_W   = $clog2(MAX_STEPS),
  localparam int ADDR_W   = OP_W + STEP_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic [OP_W-1:0]    opcode,
  input  logic [2:0]         subop,
  input  logic               cond,
  input  logic               mem_ready,
  input  logic               trap_req,
  input  logic [CAUSE_W-1:0] trap_cause_in,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ucode_we,
  input  logic               ucode_sel,
  input  logic [ADDR_W-1:0]  ucode_addr,
  input  logic [CTRL_W-1:0]  ucode_wdata,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [STEP_W-1:0]  step,
  output logic               trap_taken,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic [3:0]         irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [63:0]        instret
);

  localparam int SUB_W   = 3 + STEP_W;
  localparam int B_INC   = CTRL_W - OFS_STEP_INC;
  localparam int B_RESET = CTRL_W - OFS_STEP_RESET;
  localparam int B_COND  = CTRL_W - OFS_COND;
  localparam int B_WAIT  = CTRL_W - OFS_WAIT_MEM;
  localparam int B_SUB   = CTRL_W - OFS_SUB_MERGE;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  logic [CTRL_W-1:0] main_tbl [2**ADDR_W];
  logic [CTRL_W-1:0] sub_tbl  [2**SUB_W];

  logic [SUB_W-1:0]   sub_waddr;
  logic [CTRL_W-1:0]  main_word;
  logic [CTRL_W-1:0]  sub_word;
  logic [CTRL_W-1:0]  word;
  logic [STEP_W-1:0]  step_nxt;
  logic               retire;
  logic               trap_fire;
  logic [CAUSE_W-1:0] cause_nxt;
  logic [3:0]         id_nxt;
  logic               irq_any;
  logic               irq_take;
  logic [3:0]         irq_sel;

  // The sub-table row is the low three bits of the row field.
  assign sub_waddr = {ucode_addr[STEP_W+2:STEP_W], ucode_addr[STEP_W-1:0]};

  always_ff @(posedge clk) begin
    if (ucode_we && !run) begin
      if (ucode_sel) sub_tbl[sub_waddr] <= ucode_wdata;
      else           main_tbl[ucode_addr] <= ucode_wdata;
    end
  end

  assign main_word = main_tbl[{opcode, step}];
  assign sub_word  = sub_tbl[{subop, step}];
  assign word      = main_word | (main_word[B_SUB] ? sub_word : '0);
  assign ctrl_out  = (run && !trap_req) ? word : '0;

  useq_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq),
    .take    (irq_take),
    .pending (irq_pending),
    .any     (irq_any),
    .id      (irq_sel)
  );

  // Retire only arises in the non-trap branches, so trap_req leaves interrupts pending.
  assign irq_take = retire && irq_any;

  always_comb begin
    step_nxt  = step;
    retire    = 1'b0;
    trap_fire = 1'b0;
    cause_nxt = '0;
    id_nxt    = '0;
    if (!run) begin
      step_nxt = '0;
    end else if (trap_req) begin
      step_nxt  = '0;
      trap_fire = 1'b1;
      cause_nxt = trap_cause_in;
    end else if (word[B_WAIT] && !mem_ready) begin
      step_nxt = step;
    end else if (word[B_COND]) begin
      if (cond) begin
        step_nxt = step + 1'b1;
      end else begin
        step_nxt = '0;
        retire   = 1'b1;
      end
    end else if (word[B_RESET]) begin
      step_nxt = '0;
      retire   = 1'b1;
    end else if (word[B_INC]) begin
      if (step == LAST_STEP) begin
        step_nxt  = '0;
        trap_fire = 1'b1;
        cause_nxt = CAUSE_W'(CAUSE_ILLEGAL);
      end else begin
        step_nxt = step + 1'b1;
      end
    end
    if (irq_take) begin
      step_nxt  = '0;
      trap_fire = 1'b1;
      cause_nxt = CAUSE_W'(CAUSE_EXT_IRQ);
      id_nxt    = irq_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step       <= '0;
      trap_taken <= 1'b0;
      trap_cause <= '0;
      irq_id     <= '0;
      instret    <= '0;
    end else begin
      step       <= step_nxt;
      trap_taken <= trap_fire;
      trap_cause <= cause_nxt;
      irq_id     <= id_nxt;
      if (retire) instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Bench for useq_sequencer: per-scenario tasks with inline checks, plus a
// trap scoreboard fed by the tasks and drained when trap_taken pulses.
module tb_useq_sequencer;

  localparam logic [31:0] INC   = 32'h8000_0000;
  localparam logic [31:0] RST   = 32'h4000_0000;
  localparam logic [31:0] CND   = 32'h2000_0000;
  localparam logic [31:0] WAITM = 32'h1000_0000;
  localparam logic [31:0] SUBM  = 32'h0800_0000;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [4:0]  opcode;
  logic [2:0]  subop;
  logic        cond;
  logic        mem_ready;
  logic        trap_req;
  logic [4:0]  trap_cause_in;
  logic [3:0]  irq;
  logic        ucode_we;
  logic        ucode_sel;
  logic [7:0]  ucode_addr;
  logic [31:0] ucode_wdata;
  logic [31:0] ctrl_out;
  logic [2:0]  step;
  logic        trap_taken;
  logic [4:0]  trap_cause;
  logic [3:0]  irq_id;
  logic [3:0]  irq_pending;
  logic [63:0] instret;

  typedef struct {
    logic [4:0] cause;
    logic [3:0] id;
  } trap_exp_t;

  trap_exp_t   trap_q[$];
  trap_exp_t   te;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_instret = 64'd0;

  useq_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .opcode        (opcode),
    .subop         (subop),
    .cond          (cond),
    .mem_ready     (mem_ready),
    .trap_req      (trap_req),
    .trap_cause_in (trap_cause_in),
    .irq           (irq),
    .ucode_we      (ucode_we),
    .ucode_sel     (ucode_sel),
    .ucode_addr    (ucode_addr),
    .ucode_wdata   (ucode_wdata),
    .ctrl_out      (ctrl_out),
    .step          (step),
    .trap_taken    (trap_taken),
    .trap_cause    (trap_cause),
    .irq_id        (irq_id),
    .irq_pending   (irq_pending),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trap scoreboard drain.
  always @(negedge clk) begin
    #1;
    if (reset_n === 1'b1 && trap_taken === 1'b1) begin
      n_checks++;
      if (trap_q.size() == 0) begin
        $display("FAIL trap_unexpected: got cause %0d id %0d, expected no trap", trap_cause, irq_id);
      end else begin
        te = trap_q.pop_front();
        if (trap_cause !== te.cause || irq_id !== te.id)
          $display("FAIL trap_event: got cause %0d id %0d, expected cause %0d id %0d",
                   trap_cause, irq_id, te.cause, te.id);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic sel, input logic [4:0] row, input logic [2:0] stp, input logic [31:0] data);
    ucode_we    = 1'b1;
    ucode_sel   = sel;
    ucode_addr  = {row, stp};
    ucode_wdata = data;
    @(negedge clk);
    ucode_we = 1'b0;
  endtask

  task automatic push_trap(input int cause, input int id);
    trap_exp_t t;
    t.cause = 5'(cause);
    t.id    = 4'(id);
    trap_q.push_back(t);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; opcode = '0; subop = '0; cond = 1'b0;
    mem_ready = 1'b1; trap_req = 1'b0; trap_cause_in = '0; irq = '0;
    ucode_we = 1'b0; ucode_sel = 1'b0; ucode_addr = '0; ucode_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if (step !== 3'd0) $display("FAIL rst_step: got %0d expected 0", step); else n_pass++;
    n_checks++; if (instret !== 64'd0) $display("FAIL rst_instret: got %0d expected 0", instret); else n_pass++;
    n_checks++; if (irq_pending !== 4'd0) $display("FAIL rst_pending: got %b expected 0000", irq_pending); else n_pass++;
    n_checks++; if (trap_taken !== 1'b0) $display("FAIL rst_trap: got %b expected 0", trap_taken); else n_pass++;
    n_checks++; if (ctrl_out !== 32'd0) $display("FAIL rst_ctrl: got %h expected 0", ctrl_out); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 32; r++)
      for (int s = 0; s < 8; s++) wr(1'b0, 5'(r), 3'(s), 32'h0);
    for (int r = 0; r < 8; r++)
      for (int s = 0; s < 8; s++) wr(1'b1, 5'(r), 3'(s), 32'h0);
  endtask

  task automatic test_basic();
    int          es[4] = '{0, 1, 2, 0};
    logic [31:0] ew[4];
    ew = '{INC | 32'h0A, INC | 32'h0B, RST | 32'h0C, INC | 32'h0A};
    wr(1'b0, 5'd3, 3'd0, ew[0]);
    wr(1'b0, 5'd3, 3'd1, ew[1]);
    wr(1'b0, 5'd3, 3'd2, ew[2]);
    opcode = 5'd3; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      if (i == 3) exp_instret++;
      n_checks++; if (step !== 3'(es[i])) $display("FAIL basic_step%0d: got %0d expected %0d", i, step, es[i]); else n_pass++;
      n_checks++; if (ctrl_out !== ew[i]) $display("FAIL basic_ctrl%0d: got %h expected %h", i, ctrl_out, ew[i]); else n_pass++;
      n_checks++; if (instret !== exp_instret) $display("FAIL basic_instret%0d: got %0d expected %0d", i, instret, exp_instret); else n_pass++;
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    logic [31:0] w1 = WAITM | INC | 32'h2;
    wr(1'b0, 5'd4, 3'd0, INC | 32'h1);
    wr(1'b0, 5'd4, 3'd1, w1);
    wr(1'b0, 5'd4, 3'd2, RST | 32'h3);
    opcode = 5'd4; mem_ready = 1'b0; run = 1'b1;
    #2;
    n_checks++; if (step !== 3'd0) $display("FAIL wait_start: got %0d expected 0", step); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) mem_ready = 1'b1;
      #2;
      n_checks++; if (step !== 3'd1) $display("FAIL wait_hold%0d: got %0d expected 1", k, step); else n_pass++;
      n_checks++; if (ctrl_out !== w1) $display("FAIL wait_ctrl%0d: got %h expected %h", k, ctrl_out, w1); else n_pass++;
    end
    @(negedge clk); #2;
    n_checks++; if (step !== 3'd2) $display("FAIL wait_adv: got %0d expected 2", step); else n_pass++;
    @(negedge clk); #2;
    exp_instret++;
    n_checks++; if (instret !== exp_instret) $display("FAIL wait_instret: got %0d expected %0d", instret, exp_instret); else n_pass++;
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cond();
    int es[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 0};
    for (int s = 0; s < 3; s++) wr(1'b0, 5'd5, 3'(s), INC | 32'(s));
    wr(1'b0, 5'd5, 3'd3, CND | 32'h33);
    wr(1'b0, 5'd5, 3'd4, RST | 32'h44);
    opcode = 5'd5; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      cond = (i < 5);
      #2;
      if (i > 0 && es[i] == 0) exp_instret++;
      n_checks++; if (step !== 3'(es[i])) $display("FAIL cond_step%0d: got %0d expected %0d", i, step, es[i]); else n_pass++;
      n_checks++; if (instret !== exp_instret) $display("FAIL cond_instret%0d: got %0d expected %0d", i, instret, exp_instret); else n_pass++;
    end
    run = 1'b0; cond = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    for (int s = 0; s < 8; s++) wr(1'b0, 5'd6, 3'(s), INC | 32'(s));
    opcode = 5'd6; run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 7) push_trap(2, 0);
      #2;
      n_checks++; if (step !== 3'(i % 8)) $display("FAIL ovf_step%0d: got %0d expected %0d", i, step, i % 8); else n_pass++;
    end
    n_checks++; if (instret !== exp_instret) $display("FAIL ovf_instret: got %0d expected %0d", instret, exp_instret); else n_pass++;
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_trap();
    opcode = 5'd3; run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    trap_req = 1'b1; trap_cause_in = 5'd5;
    push_trap(5, 0);
    #2;
    n_checks++; if (step !== 3'd2) $display("FAIL trap_at_step: got %0d expected 2", step); else n_pass++;
    n_checks++; if (ctrl_out !== 32'd0) $display("FAIL trap_ctrl: got %h expected 0", ctrl_out); else n_pass++;
    @(negedge clk);
    trap_req = 1'b0; trap_cause_in = '0;
    #2;
    n_checks++; if (step !== 3'd0) $display("FAIL trap_step: got %0d expected 0", step); else n_pass++;
    n_checks++; if (instret !== exp_instret) $display("FAIL trap_instret: got %0d expected %0d", instret, exp_instret); else n_pass++;
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sub_merge();
    logic [31:0] mw = SUBM | RST | 32'h100;
    wr(1'b0, 5'd2, 3'd0, mw);
    wr(1'b1, 5'd5, 3'd0, 32'h0F);
    opcode = 5'd2; subop = 3'd5; run = 1'b1;
    #2;
    n_checks++; if (ctrl_out !== (mw | 32'h0F)) $display("FAIL sub_merge: got %h expected %h", ctrl_out, mw | 32'h0F); else n_pass++;
    @(negedge clk);
    subop = 3'd4;
    #2;
    n_checks++; if (ctrl_out !== mw) $display("FAIL sub_empty: got %h expected %h", ctrl_out, mw); else n_pass++;
    @(negedge clk);
    run = 1'b0; subop = 3'd0;
    exp_instret += 64'd2;
    #2;
    n_checks++; if (instret !== exp_instret) $display("FAIL sub_instret: got %0d expected %0d", instret, exp_instret); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_irq();
    logic got;
    for (int s = 0; s < 5; s++) wr(1'b0, 5'd7, 3'(s), INC | 32'(s));
    wr(1'b0, 5'd7, 3'd5, RST | 32'h55);
    opcode = 5'd7; run = 1'b1;
    @(negedge clk);
    irq = 4'b0101;
    push_trap(11, 0);
    push_trap(11, 2);
    for (int n = 0; n < 2; n++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (trap_taken === 1'b1) got = 1'b1;
      end
      #2;
      exp_instret++;
      n_checks++; if (got !== 1'b1) $display("FAIL irq_timeout%0d: got no trap expected trap", n); else n_pass++;
      n_checks++; if (irq_pending !== (n == 0 ? 4'b0100 : 4'b0000))
        $display("FAIL irq_pending%0d: got %b expected %b", n, irq_pending, (n == 0 ? 4'b0100 : 4'b0000)); else n_pass++;
      n_checks++; if (step !== 3'd0) $display("FAIL irq_step%0d: got %0d expected 0", n, step); else n_pass++;
      n_checks++; if (instret !== exp_instret) $display("FAIL irq_instret%0d: got %0d expected %0d", n, instret, exp_instret); else n_pass++;
    end
    run = 1'b0; irq = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    opcode = 5'd7; run = 1'b1; irq = 4'b0010;
    repeat (3) @(negedge clk);
    #2;
    n_checks++; if (step !== 3'd3) $display("FAIL arst_pre_step: got %0d expected 3", step); else n_pass++;
    n_checks++; if (irq_pending !== 4'b0010) $display("FAIL arst_pre_pending: got %b expected 0010", irq_pending); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    exp_instret = 64'd0;
    n_checks++; if (step !== 3'd0) $display("FAIL arst_step: got %0d expected 0", step); else n_pass++;
    n_checks++; if (instret !== 64'd0) $display("FAIL arst_instret: got %0d expected 0", instret); else n_pass++;
    n_checks++; if (irq_pending !== 4'd0) $display("FAIL arst_pending: got %b expected 0000", irq_pending); else n_pass++;
    run = 1'b0; irq = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(1'b0, 5'd1, 3'd0, 32'h0000_5A5A);
    opcode = 5'd1; run = 1'b1;
    #2;
    n_checks++; if (ctrl_out !== 32'h0000_5A5A) $display("FAIL arst_load: got %h expected 00005a5a", ctrl_out); else n_pass++;
    @(negedge clk);
    ucode_we = 1'b1; ucode_sel = 1'b0; ucode_addr = {5'd1, 3'd0}; ucode_wdata = 32'h0000_FFFF;
    @(negedge clk);
    ucode_we = 1'b0;
    #2;
    n_checks++; if (ctrl_out !== 32'h0000_5A5A) $display("FAIL we_while_run: got %h expected 00005a5a", ctrl_out); else n_pass++;
    n_checks++; if (step !== 3'd0) $display("FAIL arst_hold_step: got %0d expected 0", step); else n_pass++;
    @(negedge clk);
    opcode = 5'd3;
    #2;
    n_checks++; if (ctrl_out !== (INC | 32'h0A)) $display("FAIL tbl_survives: got %h expected %h", ctrl_out, INC | 32'h0A); else n_pass++;
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_cond();
    test_overflow();
    test_trap();
    test_sub_merge();
    test_irq();
    test_async_reset();
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (trap_q.size() != 0) $display("FAIL trap_missing: got %0d outstanding expected 0", trap_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/useq_sequencer.md
Name: useq_sequencer

Overview:
- Parametrised, run-time loadable microcode sequencer. It is the next-generation replacement for the fixed-table CPU control sequencer.
- It holds a main microcode table indexed by (opcode, step) and a sub-table indexed by (subop, step). It drives the datapath control word and advances the step counter with branch and memory-wait handshakes.
- It vectors traps and prioritised edge-triggered interrupts, and counts retired instructions.
- It sits between the decoder and the datapath/CSR file.

Parameters:
- OP_W, 5, opcode index width; the main table has 2**OP_W rows.
- MAX_STEPS, 8, steps per instruction, power of two, at least 4.
- CTRL_W, 32, control word width; the top 5 bits are reserved sequencing bits.
- NUM_IRQ, 4, external interrupt lines, 1 to 16.
- CAUSE_W, 5, trap cause width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = sequence; 0 = halted (step held 0, ctrl_out 0).
- opcode  in  OP_W  current instruction opcode; held stable by the datapath while step != 0.
- subop  in  3  func3 of the current instruction.
- cond  in  1  branch comparison result.
- mem_ready  in  1  memory data ready.
- trap_req  in  1  synchronous trap request from decode/address checks.
- trap_cause_in  in  CAUSE_W  cause accompanying trap_req.
- irq  in  NUM_IRQ  asynchronous external interrupt lines.
- ucode_we  in  1  microcode write strobe.
- ucode_sel  in  1  0 = main table, 1 = sub-table.
- ucode_addr  in  OP_W+log2(MAX_STEPS)  {row, step}; the sub-table uses the low 3 row bits.
- ucode_wdata  in  CTRL_W  control word to write.
- ctrl_out  out  CTRL_W  active control word (combinational).
- step  out  log2(MAX_STEPS)  current step.
- trap_taken  out  1  one-cycle pulse when a trap or interrupt is vectored.
- trap_cause  out  CAUSE_W  cause, valid with trap_taken.
- irq_id  out  4  index of the taken interrupt, valid with trap_taken.
- irq_pending  out  NUM_IRQ  latched pending interrupts.
- instret  out  64  retired instruction count.

Behaviour:
- Reset (async, reset_n=0): step, instret, irq_pending, synchroniser flops and trap_taken all 0. Microcode tables are not reset; they are zero at power-up and loaded with run=0.
- Sequencing bits: CTRL_W-1 STEP_INC, -2 STEP_RESET, -3 COND, -4 WAIT_MEM, -5 SUB_MERGE.
- Word lookup: word = main[opcode][step], OR'd with sub[subop][step] when main word has SUB_MERGE set.
- ctrl_out:
  - = word when run=1 and trap_req=0.
  - = 0 when run=0 or trap_req=1.
  - The reserved bits are passed through.
- Posedge priority, highest first:
  1. run=0: step<=0.
  2. trap_req: step<=0; trap_taken pulse; trap_cause=trap_cause_in; no retire.
  3. WAIT_MEM and !mem_ready: hold step.
  4. COND: cond=1 -> step+1; cond=0 -> step<=0 (retire).
  5. STEP_RESET: step<=0 (retire); STEP_RESET wins over STEP_INC.
  6. STEP_INC: step+1.
  7. Otherwise: hold.
- Step overflow: STEP_INC at step MAX_STEPS-1 is a microcode fault. It sets step<=0 and pulses trap_taken with cause 2 (illegal instruction); no retire.
- Retire event: instret increments by 1 and wraps at 2**64.
- Interrupts:
  - Each line passes through a 2-flop synchroniser; a rising edge sets its irq_pending bit.
  - On a retire event with any bit pending, the lowest-index pending line is taken: step<=0, trap_taken pulse, trap_cause=11, irq_id=index, and that bit clears in the same cycle.
  - The retiring instruction still counts in instret.
  - A new edge on a line that is being cleared in the same cycle keeps that bit set.
  - trap_req in the same cycle wins; interrupts stay pending.
- Microcode write: when ucode_we=1 and run=0, the word is written at posedge and is visible to lookup the next cycle. ucode_we is ignored while run=1.
- Latency: one cycle per step; memory waits extend a step indefinitely.

Decomposition:
- Package useq_pkg: reserved sequencing-bit positions, cause codes (ILLEGAL=2, EXT_IRQ=11), and a CtrlFlags enum for the datapath bits.
- Sub-module useq_irq_ctrl: synchronisers, edge detect, pending latch, priority encoder.

Test Plan:
- Load main[3] = {INC}, {INC}, {RESET}; run=1, opcode=3 -> step 0,1,2,0; instret 0 -> 1; ctrl_out equals the loaded words each cycle.
- Step 1 word = WAIT_MEM|INC, mem_ready low for 3 cycles -> step stays 1 for 3 cycles, advances on the 4th; ctrl_out stable throughout.
- COND word at step 3: cond=1 -> step 4; cond=0 -> step 0 and instret+1.
- trap_req with cause 5 at step 2 -> ctrl_out=0 that cycle; trap_taken pulse with cause 5; step 0; instret unchanged.
- irq[2] and irq[0] rise mid-instruction -> at retire, irq_id=0, cause 11, pending=0b0100. At the next retire, irq_id=2, pending=0.
- Async reset_n pulse mid-step (step=3) -> step, instret and pending become 0 immediately. After release with run=0, a write to main[1][0] followed by run=1, opcode=1 -> ctrl_out equals the written word.
